// File: rtl/decode.sv
// decode: RV32I decode stage with load-use stall, WB bypass and redirect squash.
// Optional DECODE_ILLEGAL_TRAP_EN: unrecognised encodings raise ctrl.illegal.
module decode #(
  parameter int FLUSH_SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] insn,
  input  logic [31:0] pc_de,
  input  logic        ex_stall,
  input  logic        pc_ex_valid,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        de_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic [9:0]  ex_ctrl
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_MISC  = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  localparam int C_LUI   = 9;
  localparam int C_AUIPC = 8;
  localparam int C_JAL   = 7;
  localparam int C_JALR  = 6;
  localparam int C_BR    = 5;
  localparam int C_LD    = 4;
  localparam int C_ST    = 3;
  localparam int C_OPIMM = 2;
  localparam int C_OP    = 1;
  localparam int C_ILL   = 0;

  // classes that write a destination register
  localparam logic [9:0] RD_MASK = 10'b11_1101_0110;

  localparam logic [1:0] SH_INIT   = 2'(FLUSH_SHADOW);
  localparam logic [1:0] SH_RELOAD = 2'(FLUSH_SHADOW - 1);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_rs1_val;
  logic [31:0] r_rs2_val;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [3:0]  r_alu_op;
  logic [9:0]  r_ctrl;
  logic [1:0]  r_shadow;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_br;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_is_opimm;
  logic        w_is_op;
  logic        w_is_misc;
  logic        w_is_sys;

  logic        w_br_ok;
  logic        w_ld_ok;
  logic        w_st_ok;

  logic [9:0]  w_cls;
  logic [31:0] w_imm;
  logic        w_bad;
  logic [4:0]  w_dst;
  logic        w_alt;
  logic        w_use1;
  logic        w_use2;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_ld_hit;
  logic        w_shadow;
  logic        w_issue;

  assign w_opc = insn[6:0];
  assign w_f3  = insn[14:12];
  assign w_rs1 = insn[19:15];
  assign w_rs2 = insn[24:20];
  assign w_rd  = insn[11:7];

  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;

  assign w_imm_i = {{20{insn[31]}}, insn[31:20]};
  assign w_imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign w_imm_b = {{19{insn[31]}}, insn[31], insn[7],
                    insn[30:25], insn[11:8], 1'b0};
  assign w_imm_u = {insn[31:12], 12'b0};
  assign w_imm_j = {{11{insn[31]}}, insn[31], insn[19:12],
                    insn[20], insn[30:21], 1'b0};

  assign w_is_lui   = (w_opc == OPC_LUI);
  assign w_is_auipc = (w_opc == OPC_AUIPC);
  assign w_is_jal   = (w_opc == OPC_JAL);
  assign w_is_jalr  = (w_opc == OPC_JALR);
  assign w_is_br    = (w_opc == OPC_BR);
  assign w_is_ld    = (w_opc == OPC_LD);
  assign w_is_st    = (w_opc == OPC_ST);
  assign w_is_opimm = (w_opc == OPC_OPIMM);
  assign w_is_op    = (w_opc == OPC_OP);
  assign w_is_misc  = (w_opc == OPC_MISC);
  assign w_is_sys   = (w_opc == OPC_SYS);

  // funct3 encodings reserved in RV32I for branch, load and store
  assign w_br_ok = (w_f3[2:1] != 2'b01);
  assign w_ld_ok = (w_f3 != 3'b011) && (w_f3[2:1] != 2'b11);
  assign w_st_ok = !w_f3[2] && (w_f3 != 3'b011);

  // Opcode decoder: one-hot class and format-selected immediate.
  always_comb begin
    w_cls = '0;
    w_imm = '0;
    w_bad = 1'b0;
    unique case (1'b1)
      w_is_lui: begin
        w_cls[C_LUI] = 1'b1;
        w_imm = w_imm_u;
      end
      w_is_auipc: begin
        w_cls[C_AUIPC] = 1'b1;
        w_imm = w_imm_u;
      end
      w_is_jal: begin
        w_cls[C_JAL] = 1'b1;
        w_imm = w_imm_j;
      end
      w_is_jalr: begin
        w_cls[C_JALR] = 1'b1;
        w_imm = w_imm_i;
      end
      w_is_br: begin
        if (w_br_ok) begin
          w_cls[C_BR] = 1'b1;
          w_imm = w_imm_b;
        end else begin
          w_bad = 1'b1;
        end
      end
      w_is_ld: begin
        if (w_ld_ok) begin
          w_cls[C_LD] = 1'b1;
          w_imm = w_imm_i;
        end else begin
          w_bad = 1'b1;
        end
      end
      w_is_st: begin
        if (w_st_ok) begin
          w_cls[C_ST] = 1'b1;
          w_imm = w_imm_s;
        end else begin
          w_bad = 1'b1;
        end
      end
      w_is_opimm: begin
        w_cls[C_OPIMM] = 1'b1;
        w_imm = w_imm_i;
      end
      w_is_op: begin
        w_cls[C_OP] = 1'b1;
      end
      w_is_misc, w_is_sys: begin
        w_bad = 1'b0;
      end
      default: begin
        w_bad = 1'b1;
      end
    endcase
    w_cls[C_ILL] = TRAP_EN & w_bad;
  end

  assign w_dst = (|(w_cls & RD_MASK)) ? w_rd : 5'd0;

  assign w_alt = insn[30] &
                 (w_cls[C_OP] | (w_cls[C_OPIMM] & (w_f3 == 3'b101)));

  assign w_use1 = |w_cls[C_JALR:C_ILL];
  assign w_use2 = w_cls[C_BR] | w_cls[C_ST] | w_cls[C_OP];

  assign w_op1 = (w_rs1 == 5'd0) ? 32'd0 :
                 (wb_we && (wb_rd == w_rs1)) ? wb_data : rs1_data;
  assign w_op2 = (w_rs2 == 5'd0) ? 32'd0 :
                 (wb_we && (wb_rd == w_rs2)) ? wb_data : rs2_data;

  assign w_ld_hit = r_valid && r_ctrl[C_LD] && (r_rd != 5'd0) &&
                    ((w_use1 && (w_rs1 == r_rd)) ||
                     (w_use2 && (w_rs2 == r_rd)));

  assign w_shadow = (r_shadow != 2'd0);

  assign w_issue = !pc_ex_valid && !w_shadow && !w_ld_hit;

  assign de_stall = !ex_stall && !pc_ex_valid && !w_shadow && w_ld_hit;

  // Squash counter: armed by reset or redirect, drains one slot per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= SH_INIT;
    end else if (!ex_stall) begin
      if (pc_ex_valid) begin
        r_shadow <= SH_RELOAD;
      end else if (w_shadow) begin
        r_shadow <= r_shadow - 2'd1;
      end
    end
  end

  // Decode bundle: hold on ex_stall, else capture decode or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_alu_op  <= '0;
      r_ctrl    <= '0;
    end else if (!ex_stall) begin
      r_valid   <= w_issue;
      r_pc      <= w_issue ? pc_de : '0;
      r_rs1_val <= w_issue ? w_op1 : '0;
      r_rs2_val <= w_issue ? w_op2 : '0;
      r_imm     <= w_issue ? w_imm : '0;
      r_rd      <= w_issue ? w_dst : '0;
      r_alu_op  <= w_issue ? {w_alt, w_f3} : '0;
      r_ctrl    <= w_issue ? w_cls : '0;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_pc      = r_pc;
  assign ex_rs1_val = r_rs1_val;
  assign ex_rs2_val = r_rs2_val;
  assign ex_imm     = r_imm;
  assign ex_rd      = r_rd;
  assign ex_alu_op  = r_alu_op;
  assign ex_ctrl    = r_ctrl;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed plan checks plus randomized stream against
// a behavioural RV32I decode model.
module tb_decode;

  localparam int FS = 2;

  localparam logic [9:0] K_LUI   = 10'h200;
  localparam logic [9:0] K_AUIPC = 10'h100;
  localparam logic [9:0] K_JAL   = 10'h080;
  localparam logic [9:0] K_JALR  = 10'h040;
  localparam logic [9:0] K_BR    = 10'h020;
  localparam logic [9:0] K_LD    = 10'h010;
  localparam logic [9:0] K_ST    = 10'h008;
  localparam logic [9:0] K_OPI   = 10'h004;
  localparam logic [9:0] K_OP    = 10'h002;
  localparam logic [9:0] K_ILL   = 10'h001;

  localparam logic [9:0] HAS_RD  =
    K_LUI | K_AUIPC | K_JAL | K_JALR | K_LD | K_OPI | K_OP;
  localparam logic [9:0] NO_RS1  = K_LUI | K_AUIPC | K_JAL;
  localparam logic [9:0] USE_RS2 = K_BR | K_ST | K_OP;

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_A103;
  localparam logic [31:0] ADD  = 32'h0011_01B3;
  localparam logic [31:0] LUI  = 32'h1234_52B7;

  logic        clk;
  logic        rst_n;
  logic [31:0] insn;
  logic [31:0] pc_de;
  logic        ex_stall;
  logic        pc_ex_valid;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        de_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [9:0]  ex_ctrl;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [9:0]  ctrl;
  } bun_t;

  bun_t m;
  int   m_cnt;
  bit   m_hold;
  int   n_cmp;
  int   n_bad;
  logic [9:0] ill_exp;

  decode #(.FLUSH_SHADOW(FS)) dut (
    .clk(clk), .rst_n(rst_n), .insn(insn), .pc_de(pc_de),
    .ex_stall(ex_stall), .pc_ex_valid(pc_ex_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .de_stall(de_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_ctrl(ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int imm_i(int s);
    return s >>> 20;
  endfunction

  function automatic int imm_s(int s);
    int hi;
    hi = s >>> 25;
    return (hi << 5) | ((s >> 7) & 31);
  endfunction

  function automatic int imm_b(int s);
    int hi;
    hi = s >>> 31;
    return (hi << 12) | (((s >> 7) & 1) << 11) |
           (((s >> 25) & 63) << 5) | (((s >> 8) & 15) << 1);
  endfunction

  function automatic int imm_j(int s);
    int hi;
    hi = s >>> 31;
    return (hi << 20) | (((s >> 12) & 255) << 12) |
           (((s >> 20) & 1) << 11) | (((s >> 21) & 1023) << 1);
  endfunction

  function automatic logic [31:0] opnd(logic [4:0] r, logic [31:0] d);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return d;
  endfunction

  function automatic bun_t ref_decode();
    bun_t b;
    int s;
    logic [2:0] f3;
    bit bad;
    b = '0;
    s = insn;
    f3 = insn[14:12];
    bad = 0;
    b.valid = 1'b1;
    b.pc = pc_de;
    b.rs1 = opnd(insn[19:15], rs1_data);
    b.rs2 = opnd(insn[24:20], rs2_data);
    b.op = {1'b0, f3};
    case (insn[6:0])
      7'h37: begin b.ctrl = K_LUI;   b.imm = insn & 32'hFFFF_F000; end
      7'h17: begin b.ctrl = K_AUIPC; b.imm = insn & 32'hFFFF_F000; end
      7'h6F: begin b.ctrl = K_JAL;   b.imm = imm_j(s); end
      7'h67: begin b.ctrl = K_JALR;  b.imm = imm_i(s); end
      7'h63: begin
        if (f3 inside {3'd2, 3'd3}) bad = 1;
        else begin b.ctrl = K_BR; b.imm = imm_b(s); end
      end
      7'h03: begin
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          b.ctrl = K_LD; b.imm = imm_i(s);
        end else bad = 1;
      end
      7'h23: begin
        if (f3 <= 3'd2) begin b.ctrl = K_ST; b.imm = imm_s(s); end
        else bad = 1;
      end
      7'h13: begin
        b.ctrl = K_OPI;
        b.imm = imm_i(s);
        if (f3 == 3'd5) b.op[3] = insn[30];
      end
      7'h33: begin b.ctrl = K_OP; b.op[3] = insn[30]; end
      7'h0F, 7'h73: bad = 0;
      default: bad = 1;
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (bad) b.ctrl = K_ILL;
`endif
    if ((b.ctrl & HAS_RD) != 0) b.rd = insn[11:7];
    return b;
  endfunction

  function automatic bit ld_hit();
    bun_t c;
    bit u1;
    bit u2;
    c = ref_decode();
    u1 = (c.ctrl & ~NO_RS1) != 0;
    u2 = (c.ctrl & USE_RS2) != 0;
    return m.valid && ((m.ctrl & K_LD) != 0) && m.rd != 0 &&
           ((u1 && insn[19:15] == m.rd) || (u2 && insn[24:20] == m.rd));
  endfunction

  function automatic bit exp_stall();
    return !ex_stall && !pc_ex_valid && m_cnt == 0 && ld_hit();
  endfunction

  // reference pipeline register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '0;
      m_cnt = FS;
      m_hold = 0;
    end else begin
      m_hold = ex_stall || exp_stall();
      if (!ex_stall) begin
        if (pc_ex_valid) begin
          m = '0;
          m_cnt = FS - 1;
        end else if (m_cnt > 0) begin
          m = '0;
          m_cnt--;
        end else if (ld_hit()) begin
          m = '0;
        end else begin
          m = ref_decode();
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("valid", 32'(ex_valid), 32'(m.valid));
    chk("pc", ex_pc, m.pc);
    chk("rs1_val", ex_rs1_val, m.rs1);
    chk("rs2_val", ex_rs2_val, m.rs2);
    chk("imm", ex_imm, m.imm);
    chk("rd", 32'(ex_rd), 32'(m.rd));
    chk("alu_op", 32'(ex_alu_op), 32'(m.op));
    chk("ctrl", 32'(ex_ctrl), 32'(m.ctrl));
    chk("de_stall", 32'(de_stall), 32'(exp_stall()));
    chk("rs1_addr", 32'(rs1_addr), 32'(insn[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(insn[24:20]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 13);
    case (k)
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4, 5: w[6:0] = 7'h63;
      6, 7, 8: w[6:0] = 7'h03;
      9: w[6:0] = 7'h23;
      10: w[6:0] = 7'h13;
      11: w[6:0] = 7'h33;
      12: w[6:0] = w[0] ? 7'h0F : 7'h73;
      default: w[6:0] = w[6:0];
    endcase
    if (k != 13) begin
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    insn = 32'h0000_0013;
    pc_de = '0;
    ex_stall = 1'b0;
    pc_ex_valid = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    wb_we = 1'b0;
    wb_rd = '0;
    wb_data = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    ill_exp = K_ILL;
`else
    ill_exp = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_stall", 32'(de_stall), 32'd0);

    rst_n = 1'b1;
    insn = ADDI;
    pc_de = 32'h100;
    rs1_data = 32'h1234_5678;
    step();
    chk("sh0_valid", 32'(ex_valid), 32'd0);
    step();
    chk("sh1_valid", 32'(ex_valid), 32'd0);
    step();
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rd", 32'(ex_rd), 32'd1);
    chk("addi_ctrl", 32'(ex_ctrl), 32'(K_OPI));
    chk("addi_rs1", ex_rs1_val, 32'd0);

    insn = LW;
    pc_de = 32'h104;
    step();
    chk("lw_ctrl", 32'(ex_ctrl), 32'(K_LD));
    chk("lw_rd", 32'(ex_rd), 32'd2);
    insn = ADD;
    pc_de = 32'h108;
    #1;
    chk("lu_stall", 32'(de_stall), 32'd1);
    step();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_release", 32'(de_stall), 32'd0);
    wb_we = 1'b1;
    wb_rd = 5'd1;
    wb_data = 32'hDEAD_BEEF;
    rs1_data = 32'd0;
    rs2_data = 32'h1111_1111;
    step();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_rd", 32'(ex_rd), 32'd3);
    chk("add_ctrl", 32'(ex_ctrl), 32'(K_OP));
    chk("add_bypass", ex_rs2_val, 32'hDEAD_BEEF);
    chk("add_rs1", ex_rs1_val, 32'd0);
    wb_we = 1'b0;

    insn = ADDI;
    pc_de = 32'h10C;
    pc_ex_valid = 1'b1;
    step();
    chk("fl0_valid", 32'(ex_valid), 32'd0);
    step();
    chk("fl1_valid", 32'(ex_valid), 32'd0);
    pc_ex_valid = 1'b0;
    step();
    chk("fl2_valid", 32'(ex_valid), 32'd0);
    step();
    chk("fl3_valid", 32'(ex_valid), 32'd1);

    ex_stall = 1'b1;
    pc_ex_valid = 1'b1;
    insn = LUI;
    pc_de = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_imm", ex_imm, 32'd5);
      chk("hold_pc", ex_pc, 32'h10C);
      chk("hold_stall", 32'(de_stall), 32'd0);
    end
    ex_stall = 1'b0;
    pc_ex_valid = 1'b0;
    step();
    chk("lui_valid", 32'(ex_valid), 32'd1);
    chk("lui_ctrl", 32'(ex_ctrl), 32'(K_LUI));
    chk("lui_imm", ex_imm, 32'h1234_5000);
    chk("lui_rd", 32'(ex_rd), 32'd5);

    insn = 32'hFFFF_FFFF;
    pc_de = 32'h204;
    step();
    chk("ill_valid", 32'(ex_valid), 32'd1);
    chk("ill_ctrl", 32'(ex_ctrl), 32'(ill_exp));
    chk("ill_rd", 32'(ex_rd), 32'd0);

    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) rst_n = 1'b0;
      if (c == 2002) rst_n = 1'b1;
      if (!m_hold) begin
        insn = gen();
        pc_de = $urandom & 32'hFFFF_FFFC;
      end
      ex_stall = ($urandom_range(0, 9) == 0);
      pc_ex_valid = ($urandom_range(0, 11) == 0);
      rs1_data = $urandom;
      rs2_data = $urandom;
      wb_we = 1'($urandom_range(0, 1));
      wb_rd = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I decode stage, directly downstream of instruction fetch; consumes the fetched instruction word and its PC.
- Produces a registered decode→execute pipeline bundle: register operands, sign-extended immediate, control bits, valid.
- Owns load-use hazard detection (drives the fetch stall), writeback→decode bypass, and wrong-path squashing after an execute redirect.

Parameters:
- FLUSH_SHADOW, 2: number of consecutive decode slots squashed after a redirect or reset (range 1..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- insn  in  32  instruction word from fetch
- pc_de  in  32  PC of insn
- ex_stall  in  1  execute stall; decode register holds
- pc_ex_valid  in  1  execute redirect (branch/jump taken)
- rs1_addr  out  5  register-file read address 1 (combinational from insn[19:15])
- rs2_addr  out  5  register-file read address 2 (combinational from insn[24:20])
- rs1_data  in  32  register-file read data 1
- rs2_data  in  32  register-file read data 2
- wb_we  in  1  writeback write enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- de_stall  out  1  combinational load-use stall to fetch
- ex_valid  out  1  bundle valid
- ex_pc  out  32  PC of decoded insn
- ex_rs1_val  out  32  operand 1
- ex_rs2_val  out  32  operand 2
- ex_imm  out  32  sign-extended immediate
- ex_rd  out  5  destination register (0 if none)
- ex_alu_op  out  4  {alt, funct3}
- ex_ctrl  out  10  one-hot class {lui, auipc, jal, jalr, branch, load, store, opimm, op, illegal}

Behaviour:
- Reset (async, rst_n low): all ex_* outputs 0; shadow counter = FLUSH_SHADOW; de_stall 0. Release is synchronised by the first posedge.
- Bundle registers update on posedge only when ex_stall = 0; with ex_stall = 1 every ex_* output holds its value and pc_ex_valid is ignored (matches fetch).
- Latency: one cycle from insn/pc_de to ex_*.
- Immediates by format: I (jalr, load, opimm), S, B, U, J; all sign-extended to 32 bits, bit 0 of B/J is 0. Imm is 0 for op.
- ex_alu_op[3] = insn[30] for op, and for opimm only when funct3 = 101; otherwise 0. ex_alu_op[2:0] = funct3.
- ex_rd = insn[11:7] for lui, auipc, jal, jalr, load, opimm, op; 0 for branch, store, fence, system.
- fence and system decode as valid NOP (ctrl all 0, rd 0).
- Operand read: source x0 yields 0. If wb_we && wb_rd != 0 && wb_rd == source, use wb_data (bypass), else rs*_data.
- Source use: rs1 used by all classes except lui, auipc, jal; rs2 used by branch, store, op.
- Load-use hazard: ex_valid && ex_ctrl.load && ex_rd != 0 && a used source equals ex_rd. Result: de_stall = 1, bubble written (ex_valid <= 0, other ex_* <= 0), insn retained by fetch. Hazard is evaluated only when ex_stall = 0; otherwise de_stall = 0.
- Flush: pc_ex_valid && !ex_stall → write bubble, load counter = FLUSH_SHADOW - 1, de_stall forced 0.
- Shadow: while counter != 0 and not stalled, write bubble, decrement; hazard detection suppressed.
- Priority: reset > ex_stall hold > flush > shadow squash > hazard bubble > normal decode.
- Flush arriving while counter != 0 reloads the counter.

Optional Feature:
- DECODE_ILLEGAL_TRAP_EN defined: an unrecognised opcode (or load/store/branch with reserved funct3) produces a valid bundle with ctrl.illegal = 1, rd 0, other ctrl 0.
- Undefined: such instructions decode as valid NOP; ctrl.illegal is tied to 0.

Test Plan:
- Reset, then present 0x00500093 (addi x1,x0,5) on 3 cycles: first 2 bundles ex_valid = 0; third has ex_valid = 1, imm = 5, rd = 1, ctrl = opimm, rs1_val = 0.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3): de_stall = 1 for exactly one cycle and one bubble. Next bundle is add with rd = 3, ctrl = op.
- wb_we = 1, wb_rd = 1, wb_data = 0xDEADBEEF, rs1_data = 0 while decoding add x3,x2,x1 → ex_rs2_val = 0xDEADBEEF.
- pc_ex_valid pulse with valid instructions flowing → next 2 bundles ex_valid = 0, third valid. A second pulse during the shadow restarts the 2-cycle squash.
- ex_stall held 3 cycles mid-stream, with pc_ex_valid asserted during the stall → ex_* unchanged throughout, no flush taken.
- insn 0xFFFFFFFF: with DECODE_ILLEGAL_TRAP_EN, ex_valid = 1 and ctrl = illegal only; without it, ex_valid = 1 and ctrl = 0.
